sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Shares a single-port SRAM between the IF stage (instruction fetch) and the MEM stage (load/store). It serialises accesses, inserts a fixed number of SRAM wait cycles, and returns data with a one-cycle ready pulse. It also drives stall signals that feed the pipeline freeze/hazard inputs, so IF holds its PC and MEM holds the pipeline while their access is pending.

Parameters:
ADDR_W, 32, SRAM/requester address width
DATA_W, 32, data word width
WAIT_CYCLES, 3, cycles sram_en is held per access; legal range is 1 to 15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  IF fetch request; held until if_ready
if_addr  in  ADDR_W  fetch address (PC)
if_rdata  out  DATA_W  fetched instruction, registered
if_ready  out  1  one-cycle pulse, fetch complete
if_stall  out  1  if_req & ~if_ready (combinational)
mem_rd_req  in  1  MEM load request; held until mem_ready
mem_wr_req  in  1  MEM store request; held until mem_ready
mem_addr  in  ADDR_W  load/store address
mem_wdata  in  DATA_W  store data
mem_rdata  out  DATA_W  load data, registered
mem_ready  out  1  one-cycle pulse, load/store complete
mem_stall  out  1  (mem_rd_req|mem_wr_req) & ~mem_ready (combinational)
sram_en  out  1  SRAM access enable
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_W  SRAM address, registered
sram_wdata  out  DATA_W  SRAM write data, registered
sram_rdata  in  DATA_W  SRAM read data; valid in the last ACCESS cycle

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, last_grant=IF. All registered outputs are 0: sram_en, sram_we, sram_addr, sram_wdata, if_rdata, mem_rdata, if_ready, mem_ready. The stall outputs remain combinational from the requests.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, arbitration on each clock edge:
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the one that is not last_grant, then update last_grant. Because last_grant resets to IF, MEM wins the first tie.
  - On grant, latch addr, wdata and we into the SRAM registers, load counter=WAIT_CYCLES-1, and go to ACCESS.
  - With no request, stay in IDLE with sram_en=0.
- ACCESS:
  - sram_en=1; sram_we equals the latched we.
  - The counter decrements each cycle.
  - When counter==0 at the clock edge:
    - On a read, capture sram_rdata into the granted requester's rdata register. The other rdata register is unchanged.
    - Go to DONE; sram_en=0 and sram_we=0 next cycle.
- DONE: the granted requester's ready=1 for exactly one cycle, then return to IDLE.
- Latency: a request first sampled in IDLE at cycle 0 gives ACCESS in cycles 1..WAIT_CYCLES and ready in cycle WAIT_CYCLES+1. The earliest next grant is at the end of cycle WAIT_CYCLES+2.
- A request still asserted in the IDLE cycle after its DONE is treated as a new request, for example IF fetching the next PC.
- mem_rd_req and mem_wr_req both high: the access is a write and rd is ignored.
- Writes leave mem_rdata unchanged but still pulse mem_ready.
- Request dropped during ACCESS: the access completes and ready still pulses. No abort is supported.
- Address/data changes during ACCESS are ignored, because the values were latched at grant.
- Reset asserted mid-ACCESS or in DONE:
  - sram_en, sram_we and ready go to 0 immediately.
  - No rdata update occurs.
  - After rst releases, still-held requests restart a full access.
- The counter never wraps; the ACCESS exit is decided only on counter==0.

Test Plan:
1. IF-only read, WAIT_CYCLES=3: if_req=1, if_addr=0x10, sram_rdata=0xE3A00001 -> sram_en high in cycles 1-3 with sram_addr=0x10 and sram_we=0; if_ready pulses in cycle 4; if_rdata=0xE3A00001; if_stall high in cycles 0-3.
2. MEM store: mem_wr_req=1, mem_addr=0x400, mem_wdata=0xDEADBEEF -> sram_we=1 and sram_wdata=0xDEADBEEF in cycles 1-3; mem_ready pulses in cycle 4; mem_rdata keeps its prior value.
3. Tie after reset: if_req and mem_rd_req both held from cycle 0 -> MEM granted first (mem_ready in cycle 4); IF granted next (if_ready in cycle 9); if_stall high in cycles 0-8.
4. Continuous contention: both requesters held for 20 cycles -> grant order MEM, IF, MEM, IF; each ready pulse is exactly 1 cycle wide; sram_en is never high in a DONE cycle.
5. Reset mid-access: rst=0 in ACCESS cycle 2 -> sram_en=0 immediately; no ready pulse; if_rdata=0. rst=1 with if_req held -> full 3-cycle access followed by an if_ready pulse.
6. Both mem_rd_req and mem_wr_req high, wdata=0x12345678 -> write performed (sram_we=1); mem_ready pulses; mem_rdata unchanged.

Source files
------------

// File: rtl/sram_arbiter.sv
// Arbitrates a single-port SRAM between instruction fetch and load/store.
// Each access holds sram_en for WAIT_CYCLES cycles, then pulses the owner's ready.
module sram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_stall,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} stateT;

  localparam logic [3:0] CountInit = 4'(WAIT_CYCLES - 1);

  stateT      state;
  stateT      nextState;
  logic [3:0] counter;
  logic       lastGrant;
  logic       grantMem;
  logic       memReq;
  logic       anyReq;
  logic       pickMem;
  logic       accessEnd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (anyReq) nextState = ACCESS;
      ACCESS:  if (accessEnd) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // lastGrant is 1 when MEM owned the previous access; on a tie the other side wins.
  always_comb begin
    memReq    = mem_rd_req | mem_wr_req;
    anyReq    = if_req | memReq;
    pickMem   = memReq & (~if_req | ~lastGrant);
    accessEnd = (state == ACCESS) && (counter == 4'd0);
    if_stall  = if_req & ~if_ready;
    mem_stall = memReq & ~mem_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter    <= '0;
      lastGrant  <= 1'b0;
      grantMem   <= 1'b0;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            grantMem   <= pickMem;
            lastGrant  <= pickMem;
            sram_en    <= 1'b1;
            sram_we    <= pickMem & mem_wr_req;
            sram_addr  <= pickMem ? mem_addr : if_addr;
            sram_wdata <= pickMem ? mem_wdata : '0;
            counter    <= CountInit;
          end
        end
        ACCESS: begin
          if (counter == 4'd0) begin
            sram_en   <= 1'b0;
            sram_we   <= 1'b0;
            if_ready  <= ~grantMem;
            mem_ready <= grantMem;
            // A combined rd+wr was latched as a write, so it never touches mem_rdata.
            if (!sram_we) begin
              if (grantMem) mem_rdata <= sram_rdata;
              else          if_rdata  <= sram_rdata;
            end
          end else begin
            counter <= counter - 4'd1;
          end
        end
        DONE: begin
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
        end
        default: begin
          sram_en <= 1'b0;
          sram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a scoreboard queue holds the expected completions
// in grant order and is checked whenever a ready pulse appears.
module tb_sram_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int WAIT = 3;

  typedef struct {
    logic        isMem;
    logic [31:0] ifData;
    logic [31:0] memData;
    int          readyCycle;
  } sbEntryT;

  logic          clk = 1'b0;
  logic          rstN;
  logic          ifReq;
  logic [AW-1:0] ifAddr;
  logic [DW-1:0] ifRdata;
  logic          ifReady;
  logic          ifStall;
  logic          memRdReq;
  logic          memWrReq;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memWdata;
  logic [DW-1:0] memRdata;
  logic          memReady;
  logic          memStall;
  logic          sramEn;
  logic          sramWe;
  logic [AW-1:0] sramAddr;
  logic [DW-1:0] sramWdata;
  logic [DW-1:0] sramRdata;

  logic [31:0] sramArr [0:1023];
  sbEntryT     sbq [$];
  logic [31:0] modelIfData;
  logic [31:0] modelMemData;
  int          cyc;
  int          checkCount;
  int          passCount;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WAIT)) dut (
    .clk(clk), .rst(rstN),
    .if_req(ifReq), .if_addr(ifAddr), .if_rdata(ifRdata), .if_ready(ifReady), .if_stall(ifStall),
    .mem_rd_req(memRdReq), .mem_wr_req(memWrReq), .mem_addr(memAddr), .mem_wdata(memWdata),
    .mem_rdata(memRdata), .mem_ready(memReady), .mem_stall(memStall),
    .sram_en(sramEn), .sram_we(sramWe), .sram_addr(sramAddr), .sram_wdata(sramWdata),
    .sram_rdata(sramRdata)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM; reads return a poison word whenever the enable is low.
  always @(posedge clk) begin
    if (!rstN) begin
      sramArr[4]  <= 32'hE3A00001;
      sramArr[8]  <= 32'hCAFEF00D;
      sramArr[12] <= 32'h11112222;
    end else if (sramEn && sramWe) begin
      sramArr[sramAddr[11:2]] <= sramWdata;
    end
  end

  assign sramRdata = sramEn ? sramArr[sramAddr[11:2]] : 32'hBAD0BAD0;

  function automatic logic [31:0] refData(input logic [31:0] addr);
    case (addr)
      32'h10:  return 32'hE3A00001;
      32'h20:  return 32'hCAFEF00D;
      32'h30:  return 32'h11112222;
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    sbEntryT e;
    @(negedge clk);
    cyc++;
    if (ifReady || memReady) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_ready", {62'd0, ifReady, memReady}, 64'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("ready_owner", {62'd0, ifReady, memReady}, e.isMem ? 64'd1 : 64'd2);
        checkOutput("ready_cycle", 64'(cyc), 64'(e.readyCycle));
        checkOutput("if_rdata", 64'(ifRdata), 64'(e.ifData));
        checkOutput("mem_rdata", 64'(memRdata), 64'(e.memData));
      end
    end
  endtask

  task automatic expectDone(input logic isMem, input logic isWrite, input logic [31:0] addr, input int readyCycle);
    sbEntryT e;
    if (!isMem)        modelIfData  = refData(addr);
    else if (!isWrite) modelMemData = refData(addr);
    e.isMem      = isMem;
    e.ifData     = modelIfData;
    e.memData    = modelMemData;
    e.readyCycle = readyCycle;
    sbq.push_back(e);
  endtask

  // One uncontended access from an idle arbiter, checked cycle by cycle.
  task automatic applyStimulus(input logic isMem, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int base;
    base     = cyc;
    ifReq    = ~isMem;
    ifAddr   = addr;
    memRdReq = isMem & rd;
    memWrReq = isMem & wr;
    memAddr  = addr;
    memWdata = wdata;
    expectDone(isMem, isMem & wr, addr, base + WAIT + 1);
    #1;
    checkOutput("stall_c0", {63'd0, isMem ? memStall : ifStall}, 64'd1);
    checkOutput("en_c0", {63'd0, sramEn}, 64'd0);
    for (int k = 1; k <= WAIT; k++) begin
      tick();
      checkOutput("access_en", {63'd0, sramEn}, 64'd1);
      checkOutput("access_we", {63'd0, sramWe}, {63'd0, isMem & wr});
      checkOutput("access_addr", 64'(sramAddr), 64'(addr));
      if (isMem && wr) checkOutput("access_wdata", 64'(sramWdata), 64'(wdata));
      checkOutput("access_stall", {63'd0, isMem ? memStall : ifStall}, 64'd1);
    end
    tick();
    checkOutput("done_en", {63'd0, sramEn}, 64'd0);
    checkOutput("done_we", {63'd0, sramWe}, 64'd0);
    checkOutput("done_stall", {63'd0, isMem ? memStall : ifStall}, 64'd0);
    ifReq    = 1'b0;
    memRdReq = 1'b0;
    memWrReq = 1'b0;
    tick();
    checkOutput("idle_en", {63'd0, sramEn}, 64'd0);
  endtask

  initial begin
    int base;
    cyc = 0; checkCount = 0; passCount = 0;
    modelIfData = '0; modelMemData = '0;
    rstN = 1'b0; ifReq = 1'b0; ifAddr = '0; memRdReq = 1'b0; memWrReq = 1'b0;
    memAddr = '0; memWdata = '0;

    // Reset state, with the stall path still live from the request.
    tick(); tick();
    checkOutput("rst_en", {63'd0, sramEn}, 64'd0);
    checkOutput("rst_we", {63'd0, sramWe}, 64'd0);
    checkOutput("rst_addr", 64'(sramAddr), 64'd0);
    checkOutput("rst_wdata", 64'(sramWdata), 64'd0);
    checkOutput("rst_if_rdata", 64'(ifRdata), 64'd0);
    checkOutput("rst_mem_rdata", 64'(memRdata), 64'd0);
    checkOutput("rst_ready", {62'd0, ifReady, memReady}, 64'd0);
    ifReq = 1'b1;
    #1 checkOutput("rst_if_stall", {63'd0, ifStall}, 64'd1);
    ifReq = 1'b0;
    tick();
    rstN = 1'b1;
    tick();

    // IF fetch, MEM load, MEM store (mem_rdata must keep the loaded word).
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h400, 32'hDEADBEEF);
    checkOutput("store_landed", 64'(sramArr[256]), 64'hDEADBEEF);

    // Tie straight after reset: MEM first, IF second.
    rstN = 1'b0;
    modelIfData = '0; modelMemData = '0;
    tick();
    checkOutput("rst2_mem_rdata", 64'(memRdata), 64'd0);
    rstN = 1'b1;
    tick();
    base = cyc;
    ifReq = 1'b1; ifAddr = 32'h30;
    memRdReq = 1'b1; memAddr = 32'h20;
    expectDone(1'b1, 1'b0, 32'h20, base + 4);
    expectDone(1'b0, 1'b0, 32'h30, base + 9);
    #1 checkOutput("tie_stalls_c0", {62'd0, ifStall, memStall}, 64'd3);
    for (int k = 1; k <= 9; k++) begin
      tick();
      checkOutput("tie_if_stall", {63'd0, ifStall}, (k <= 8) ? 64'd1 : 64'd0);
      if (k <= 3) checkOutput("tie_addr_mem", 64'(sramAddr), 64'h20);
      if (k >= 6 && k <= 8) checkOutput("tie_addr_if", 64'(sramAddr), 64'h30);
      if (k == 4) begin
        checkOutput("tie_done_en", {63'd0, sramEn}, 64'd0);
        memRdReq = 1'b0;
      end
    end
    ifReq = 1'b0;
    tick();

    // Continuous contention keeps alternating, starting with MEM.
    base = cyc;
    ifReq = 1'b1; ifAddr = 32'h30;
    memRdReq = 1'b1; memAddr = 32'h20;
    expectDone(1'b1, 1'b0, 32'h20, base + 4);
    expectDone(1'b0, 1'b0, 32'h30, base + 9);
    expectDone(1'b1, 1'b0, 32'h20, base + 14);
    expectDone(1'b0, 1'b0, 32'h30, base + 19);
    for (int k = 1; k <= 19; k++) begin
      tick();
      if (ifReady || memReady) checkOutput("contend_done_en", {63'd0, sramEn}, 64'd0);
    end
    ifReq = 1'b0; memRdReq = 1'b0;
    tick();
    checkOutput("contend_idle_en", {63'd0, sramEn}, 64'd0);

    // Reset in the second ACCESS cycle aborts silently; the held fetch restarts.
    ifReq = 1'b1; ifAddr = 32'h10;
    tick(); tick();
    checkOutput("pre_abort_en", {63'd0, sramEn}, 64'd1);
    rstN = 1'b0;
    modelIfData = '0; modelMemData = '0;
    #1;
    checkOutput("abort_en", {63'd0, sramEn}, 64'd0);
    checkOutput("abort_we", {63'd0, sramWe}, 64'd0);
    checkOutput("abort_ready", {62'd0, ifReady, memReady}, 64'd0);
    checkOutput("abort_if_rdata", 64'(ifRdata), 64'd0);
    tick(); tick();
    rstN = 1'b1;
    base = cyc;
    expectDone(1'b0, 1'b0, 32'h10, base + 4);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("restart_en", {63'd0, sramEn}, 64'd1);
      checkOutput("restart_addr", 64'(sramAddr), 64'h10);
    end
    tick();
    ifReq = 1'b0;
    tick();

    // Load, then rd+wr together: treated as a write, mem_rdata untouched.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 32'h12345678);
    checkOutput("rdwr_landed", 64'(sramArr[16]), 64'h12345678);

    tick(); tick();
    checkOutput("sb_empty", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
